// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches control words indexed by {OPCODE, micro-PC},
// registers the decoded datapath controls, and walks the micro-PC through
// NEXT / END / JUMP / WAIT / HALT microops. The RAM is loaded while in BOOT.
module microcode_sequencer #(
  parameter int OPCODE_W = 6,
  parameter int UPC_W    = 5,
  parameter int CTRL_W   = 32,
  parameter int N_IN     = 8,
  parameter int N_OUT    = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [OPCODE_W-1:0]       OPCODE,
  input  logic                      COND,
  input  logic                      READY,
  input  logic                      BOOTED,
  input  logic                      BOOT_WE,
  input  logic [OPCODE_W+UPC_W-1:0] BOOT_ADDR,
  input  logic [CTRL_W-1:0]         BOOT_DATA,
  output logic [4:0]                REG_SRC,
  output logic [1:0]                REG_SEL,
  output logic [3:0]                ALU_PLANE,
  output logic [N_IN-1:0]           IN_STB,
  output logic [N_OUT-1:0]          N_OUT_EN,
  output logic [UPC_W-1:0]          UPC,
  output logic                      HALTED,
  output logic                      FAULT
);

  localparam int DEPTH = 1 << (OPCODE_W + UPC_W);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    M_NEXT = 3'd0,
    M_END  = 3'd1,
    M_JUMP = 3'd2,
    M_WAIT = 3'd3,
    M_HALT = 3'd4
  } misc_e;

  state_e state_q, state_d;

  logic [CTRL_W-1:0] mem [DEPTH];
  logic [CTRL_W-1:0] word;

  logic [4:0]       f_reg_src;
  logic [1:0]       f_reg_sel;
  logic [3:0]       f_alu;
  logic [2:0]       f_out;
  logic [2:0]       f_in;
  logic [2:0]       f_misc;
  logic [UPC_W-1:0] f_target;

  logic [N_IN-1:0]  in_dec;
  logic [N_OUT-1:0] n_out_dec;
  logic             in_fault;

  logic [UPC_W-1:0] upc_d;
  logic             fault_d;
  logic [4:0]       reg_src_d;
  logic [1:0]       reg_sel_d;
  logic [3:0]       alu_d;
  logic [N_IN-1:0]  in_stb_d;
  logic [N_OUT-1:0] n_out_en_d;
  logic             advance;

  // Microcode RAM: written only while booting; contents survive reset.
  always_ff @(posedge CLK) begin
    if (!RST && BOOT_WE && state_q == S_BOOT)
      mem[BOOT_ADDR] <= BOOT_DATA;
  end

  assign word = mem[{OPCODE, UPC}];

  assign f_reg_src = word[4:0];
  assign f_reg_sel = word[6:5];
  assign f_alu     = word[10:7];
  assign f_out     = word[13:11];
  assign f_in      = word[16:14];
  assign f_misc    = word[19:17];
  assign f_target  = word[20 +: UPC_W];

  generate
    if (CTRL_W > 20 + UPC_W) begin : g_spare
      logic unused_spare;
      assign unused_spare = ^word[CTRL_W-1:20+UPC_W];
    end
  endgenerate

  // One-hot in-plane strobe and active-low out-plane enable; code 0 selects nothing.
  always_comb begin
    in_dec    = '0;
    n_out_dec = '1;
    for (int unsigned i = 1; i < N_IN; i++)
      if (32'(f_in) == i) in_dec[i] = 1'b1;
    for (int unsigned i = 1; i < N_OUT; i++)
      if (32'(f_out) == i) n_out_dec[i] = 1'b0;
  end

  // An out-of-range in code or an in/out collision on the same plane is unsafe.
  assign in_fault = (32'(f_in) >= 32'(N_IN)) || (f_in != 3'd0 && f_in == f_out);

  // Next-state, next micro-PC and next registered outputs.
  always_comb begin
    state_d    = state_q;
    upc_d      = UPC;
    fault_d    = FAULT;
    reg_src_d  = '0;
    reg_sel_d  = '0;
    alu_d      = '0;
    in_stb_d   = '0;
    n_out_en_d = '1;
    advance    = 1'b0;

    if (BOOT_WE && state_q != S_BOOT)
      fault_d = 1'b1;

    case (state_q)
      S_BOOT: begin
        upc_d = '0;
        if (BOOTED) state_d = S_RUN;
      end
      S_RUN: begin
        reg_src_d  = f_reg_src;
        reg_sel_d  = f_reg_sel;
        alu_d      = f_alu;
        n_out_en_d = n_out_dec;
        in_stb_d   = in_fault ? '0 : in_dec;
        if (in_fault) fault_d = 1'b1;

        case (misc_e'(f_misc))
          M_NEXT: advance = 1'b1;
          M_END:  upc_d = '0;
          M_JUMP: begin
            if (COND) upc_d = f_target;
            else      advance = 1'b1;
          end
          M_WAIT: begin
            // Stalled cycles repeat the word but withhold the strobe.
            if (READY) advance = 1'b1;
            else       in_stb_d = '0;
          end
          M_HALT: state_d = S_HALT;
          default: begin
            fault_d    = 1'b1;
            state_d    = S_HALT;
            reg_src_d  = '0;
            reg_sel_d  = '0;
            alu_d      = '0;
            in_stb_d   = '0;
            n_out_en_d = '1;
          end
        endcase

        // Stepping past the last micro-op is a fault, never a silent wrap.
        if (advance) begin
          if (UPC == '1) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            upc_d = UPC + 1'b1;
          end
        end
      end
      S_HALT: ;
      default: state_d = S_HALT;
    endcase
  end

  // State, micro-PC, sticky fault and registered datapath controls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_BOOT;
      UPC       <= '0;
      FAULT     <= 1'b0;
      REG_SRC   <= '0;
      REG_SEL   <= '0;
      ALU_PLANE <= '0;
      IN_STB    <= '0;
      N_OUT_EN  <= '1;
    end else begin
      state_q   <= state_d;
      UPC       <= upc_d;
      FAULT     <= fault_d;
      REG_SRC   <= reg_src_d;
      REG_SEL   <= reg_sel_d;
      ALU_PLANE <= alu_d;
      IN_STB    <= in_stb_d;
      N_OUT_EN  <= n_out_en_d;
    end
  end

  assign HALTED = (state_q == S_HALT);

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: expected per-cycle observations are
// queued with each stimulus step and compared one cycle later.
module tb_microcode_sequencer;

  localparam int OW = 6;
  localparam int UW = 5;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [OW-1:0] opcode;
  logic          cond, ready, booted, boot_we;
  logic [OW+UW-1:0] boot_addr;
  logic [CW-1:0] boot_data;
  logic [4:0]    reg_src;
  logic [1:0]    reg_sel;
  logic [3:0]    alu_plane;
  logic [7:0]    in_stb;
  logic [7:0]    n_out_en;
  logic [UW-1:0] upc;
  logic          halted, fault;

  microcode_sequencer #(
    .OPCODE_W(OW), .UPC_W(UW), .CTRL_W(CW), .N_IN(8), .N_OUT(8)
  ) dut (
    .CLK(clk), .RST(rst), .OPCODE(opcode), .COND(cond), .READY(ready),
    .BOOTED(booted), .BOOT_WE(boot_we), .BOOT_ADDR(boot_addr),
    .BOOT_DATA(boot_data), .REG_SRC(reg_src), .REG_SEL(reg_sel),
    .ALU_PLANE(alu_plane), .IN_STB(in_stb), .N_OUT_EN(n_out_en),
    .UPC(upc), .HALTED(halted), .FAULT(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  upc;
    logic [7:0]  in_stb;
    logic [7:0]  nout;
    logic        fault;
    logic        halted;
    logic [10:0] dp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  localparam int DP3 = (9 << 7) | (2 << 5) | 'h15;

  function automatic logic [31:0] mk(int in_c, int out_c, int misc, int tgt, int dp);
    return (32'(tgt) << 20) | (32'(misc) << 17) | (32'(in_c) << 14) |
           (32'(out_c) << 11) | 32'(dp);
  endfunction

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    assert (act === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp_v);
    end
  endtask

  task automatic step(int e_upc, int e_in, int e_nout, int e_fault, int e_halted, int e_dp);
    exp_t e;
    sb.push_back('{upc: 5'(e_upc), in_stb: 8'(e_in), nout: 8'(e_nout),
                   fault: 1'(e_fault), halted: 1'(e_halted), dp: 11'(e_dp)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("upc",      32'(upc),      32'(e.upc));
    check("in_stb",   32'(in_stb),   32'(e.in_stb));
    check("n_out_en", 32'(n_out_en), 32'(e.nout));
    check("fault",    32'(fault),    32'(e.fault));
    check("halted",   32'(halted),   32'(e.halted));
    check("datapath", 32'({alu_plane, reg_sel, reg_src}), 32'(e.dp));
  endtask

  task automatic wr(int op, int u, logic [31:0] data);
    boot_we   = 1'b1;
    boot_addr = 11'(op * 32 + u);
    boot_data = data;
    step(0, 0, 'hFF, 0, 0, 0);
    boot_we   = 1'b0;
  endtask

  task automatic start(int op);
    opcode = 6'(op);
    booted = 1'b1;
    rst    = 1'b1;
    step(0, 0, 'hFF, 0, 0, 0);
    rst    = 1'b0;
    step(0, 0, 'hFF, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; opcode = '0; cond = 1'b0; ready = 1'b0; booted = 1'b0;
    boot_we = 1'b0; boot_addr = '0; boot_data = '0;

    // Reset state
    step(0, 0, 'hFF, 0, 0, 0);
    rst = 1'b0;

    // Load programs
    wr(3, 0, mk(1, 2, 0, 0, DP3));
    wr(4, 0, mk(3, 0, 0, 0, 0));
    wr(4, 1, mk(0, 0, 0, 0, 0));
    wr(4, 2, mk(0, 0, 2, 7, 0));
    wr(4, 3, mk(4, 0, 4, 0, 0));
    wr(4, 7, mk(5, 0, 4, 0, 0));
    wr(5, 0, mk(6, 1, 3, 0, 0));
    wr(5, 1, mk(0, 0, 4, 0, 0));
    for (int i = 0; i < 32; i++) wr(6, i, mk(1, 0, 0, 0, 0));
    wr(7, 0, mk(2, 2, 0, 0, 0));
    wr(7, 1, mk(0, 0, 4, 0, 0));
    wr(8, 0, mk(1, 0, 5, 0, 0));

    // Last write coincides with BOOTED: write lands and RUN starts on one edge
    opcode    = 6'd3;
    booted    = 1'b1;
    boot_we   = 1'b1;
    boot_addr = 11'(3 * 32 + 1);
    boot_data = mk(0, 0, 1, 0, 0);
    step(0, 0, 'hFF, 0, 0, 0);
    boot_we = 1'b0;

    // Opcode 3 loop: 0,1,0 with strobe/enable one cycle after UPC=0
    step(1, 'h02, 'hFB, 0, 0, DP3);
    step(0, 0, 'hFF, 0, 0, 0);
    step(1, 'h02, 'hFB, 0, 0, DP3);

    // Write attempt while running: ignored, faults
    boot_we   = 1'b1;
    boot_addr = 11'(3 * 32);
    boot_data = mk(5, 0, 0, 0, 0);
    step(0, 0, 'hFF, 1, 0, 0);
    boot_we = 1'b0;
    step(1, 'h02, 'hFB, 1, 0, DP3);

    // JUMP taken
    cond = 1'b1;
    start(4);
    step(1, 'h08, 'hFF, 0, 0, 0);
    step(2, 0, 'hFF, 0, 0, 0);
    step(7, 0, 'hFF, 0, 0, 0);
    step(7, 'h20, 'hFF, 0, 1, 0);
    step(7, 0, 'hFF, 0, 1, 0);

    // JUMP not taken
    cond = 1'b0;
    start(4);
    step(1, 'h08, 'hFF, 0, 0, 0);
    step(2, 0, 'hFF, 0, 0, 0);
    step(3, 0, 'hFF, 0, 0, 0);
    step(3, 'h10, 'hFF, 0, 1, 0);

    // WAIT stall for 4 cycles, then single strobe on release
    ready = 1'b0;
    start(5);
    repeat (4) step(0, 0, 'hFD, 0, 0, 0);
    ready = 1'b1;
    step(1, 'h40, 'hFD, 0, 0, 0);
    ready = 1'b0;
    step(1, 0, 'hFF, 0, 1, 0);

    // 32 NEXT words: stepping past UPC=31 faults and halts
    start(6);
    for (int i = 1; i < 32; i++) step(i, 'h02, 'hFF, 0, 0, 0);
    step(31, 'h02, 'hFF, 1, 1, 0);
    step(31, 0, 'hFF, 1, 1, 0);
    booted = 1'b0;
    rst    = 1'b1;
    step(0, 0, 'hFF, 0, 0, 0);
    rst    = 1'b0;
    step(0, 0, 'hFF, 0, 0, 0);

    // IN == OUT collision: strobe suppressed, out enable kept, fault
    start(7);
    step(1, 0, 'hFB, 1, 0, 0);
    step(1, 0, 'hFF, 1, 1, 0);

    // Illegal MISC code
    start(8);
    step(0, 0, 'hFF, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
